// File: rtl/rate_scan_ctrl_pkg.sv
// Shared types and constants for the time-multiplexed pulse-rate scanner.
package rate_scan_ctrl_pkg;

    localparam int CNT_W = 32;
    localparam int CH_W  = 4;

    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_GATE,
        ST_STORE
    } scan_state_e;

endpackage

// File: rtl/rate_scan_ctrl_gated_edge_counter.sv
// Saturating rising-edge counter with synchronous clear and count enable.
module gated_edge_counter
    import rate_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rise,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && rise) begin
            count_d = sat_inc(count_q);
        end
    end

    // The count is always cleared during SETTLE before use, so it needs no reset.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/rate_scan_ctrl.sv
// Scans NCH asynchronous pulse inputs through one gated edge counter and
// keeps the last edge count of each channel in a readable result bank.
module rate_scan_ctrl
    import rate_scan_ctrl_pkg::*;
#(
    parameter int NCH    = 4,
    parameter int SETTLE = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [NCH-1:0]   Pulse,
    input  logic [31:0]      GateCycles,
    input  logic             Start,
    input  logic             Continuous,
    input  logic             Stop,
    output logic             Busy,
    output logic             ScanDone,
    output logic [3:0]       CurCh,
    input  logic [3:0]       RdAddr,
    output logic [31:0]      RdData,
    output logic [NCH-1:0]   ValidMask
);

    logic [NCH-1:0][2:0] sync_q, sync_d;
    logic [NCH-1:0]      rise_vec;
    logic                ch_rise;

    scan_state_e         state_q, state_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
    logic [CNT_W-1:0]    timer_q, timer_d;
    logic [CNT_W-1:0]    gate_len_q, gate_len_d;
    logic                cont_q, cont_d;
    logic                stop_q, stop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                store_en;
    logic                last_ch;

    logic [CNT_W-1:0]    edge_count;
    logic [CNT_W-1:0]    result_q [NCH];
    logic [CNT_W-1:0]    result_d [NCH];
    logic [NCH-1:0]      valid_q, valid_d;
    logic [CNT_W-1:0]    rd_data_q, rd_data_d;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            sync_d[i]   = {sync_q[i][1:0], Pulse[i]};
            rise_vec[i] = sync_q[i][1] & ~sync_q[i][2];
        end
    end

    always_comb begin
        ch_rise = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (cur_ch_q == CH_W'(i)) ch_rise = rise_vec[i];
        end
    end

    gated_edge_counter u_cnt (
        .clk   (Clk),
        .rise  (ch_rise),
        .clr   (state_q == ST_SETTLE),
        .en    (state_q == ST_GATE),
        .count (edge_count)
    );

    assign last_ch = (cur_ch_q == CH_W'(NCH - 1));

    // One down-counting timer serves both the settle and the gate intervals.
    always_comb begin
        state_d    = state_q;
        cur_ch_d   = cur_ch_q;
        timer_d    = timer_q;
        gate_len_d = gate_len_q;
        cont_d     = cont_q;
        stop_d     = stop_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        store_en   = 1'b0;
        if (state_q != ST_IDLE && Stop) stop_d = 1'b1;
        case (state_q)
            ST_IDLE: begin
                stop_d = 1'b0;
                if (Start) begin
                    gate_len_d = (GateCycles == '0) ? CNT_W'(1) : GateCycles;
                    cont_d     = Continuous;
                    cur_ch_d   = '0;
                    timer_d    = CNT_W'(SETTLE);
                    busy_d     = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (timer_q == CNT_W'(1)) begin
                    timer_d = gate_len_q;
                    state_d = ST_GATE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            ST_GATE: begin
                if (timer_q == CNT_W'(1)) begin
                    state_d = ST_STORE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: begin
                store_en = 1'b1;
                done_d   = last_ch;
                if (stop_q || (last_ch && !cont_q)) begin
                    busy_d  = 1'b0;
                    stop_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cur_ch_d = last_ch ? '0 : cur_ch_q + 1'b1;
                    timer_d  = CNT_W'(SETTLE);
                    state_d  = ST_SETTLE;
                end
            end
        endcase
    end

    // Reading from result_d lets a read of the channel being stored see the new value.
    always_comb begin
        result_d  = result_q;
        valid_d   = valid_q;
        rd_data_d = '0;
        for (int i = 0; i < NCH; i++) begin
            if (store_en && cur_ch_q == CH_W'(i)) begin
                result_d[i] = edge_count;
                valid_d[i]  = 1'b1;
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (RdAddr == CH_W'(i)) rd_data_d = result_d[i];
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            sync_q     <= '0;
            state_q    <= ST_IDLE;
            cur_ch_q   <= '0;
            timer_q    <= '0;
            gate_len_q <= '0;
            cont_q     <= 1'b0;
            stop_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '{default: '0};
            valid_q    <= '0;
            rd_data_q  <= '0;
        end else begin
            sync_q     <= sync_d;
            state_q    <= state_d;
            cur_ch_q   <= cur_ch_d;
            timer_q    <= timer_d;
            gate_len_q <= gate_len_d;
            cont_q     <= cont_d;
            stop_q     <= stop_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            result_q   <= result_d;
            valid_q    <= valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign Busy      = busy_q;
    assign ScanDone  = done_q;
    assign CurCh     = cur_ch_q;
    assign RdData    = rd_data_q;
    assign ValidMask = valid_q;

endmodule

// File: doc/rate_scan_ctrl.md
# rate_scan_ctrl

Measurement scheduler that shares one gated rising-edge counter among `NCH` asynchronous pulse inputs (laser triggers, photodiode syncs). It scans the channels in order over a programmable gate window and stores one edge count per channel in a result bank. The Ethernet register layer configures the scan and reads the results. It replaces one free-running, fixed-1-s counter per input with a single time-multiplexed datapath.

## Interface
Parameters:
- `NCH`, 4: number of pulse inputs (2..16).
- `SETTLE`, 8: cycles discarded after each channel switch (synchronizer flush); ≥ 3.

Ports:
- `Clk`: in, 1. System clock, 50 MHz.
- `Rst`: in, 1. Synchronous, active-high reset.
- `Pulse`: in, NCH. Asynchronous pulse inputs.
- `GateCycles`: in, 32. Gate length in `Clk` cycles. Latched on `Start`; 0 is treated as 1.
- `Start`: in, 1. Begin a scan. Ignored while `Busy`.
- `Continuous`: in, 1. Latched on `Start`. When 1, the scan restarts at ch 0 after the last channel.
- `Stop`: in, 1. Ends the scan after the current channel's STORE.
- `Busy`: out, 1. High from the cycle after an accepted `Start` until the return to IDLE.
- `ScanDone`: out, 1. One-cycle pulse in the cycle after the last channel's STORE.
- `CurCh`: out, 4. Channel currently selected.
- `RdAddr`: in, 4. Result bank read address.
- `RdData`: out, 32. `Result[RdAddr]`, registered with 1-cycle latency; 0 if `RdAddr ≥ NCH`.
- `ValidMask`: out, NCH. Bit i is set once `Result[i]` has been written since reset.

## Operation
- Every `Pulse[i]` passes through its own 3-flop synchronizer. A rise is detected when `sync[2:1] == 01`. Only `CurCh` feeds the counter.
- Behaviour by state:
  - IDLE: on `Start`, latch `GateCycles` (0→1) and `Continuous`, set `CurCh`=0, go to SETTLE.
  - SETTLE: run exactly `SETTLE` cycles, ignoring rises, then clear the edge count and load the gate timer. Go to GATE.
  - GATE: run exactly G cycles. Each detected rise increments the 32-bit edge count, which saturates at 0xFFFFFFFF and does not wrap. Go to STORE.
  - STORE: run 1 cycle and write `Result[CurCh]` ← count and set `ValidMask[CurCh]`.
    - If `CurCh < NCH-1` and no stop is pending: `CurCh`+1, go to SETTLE.
    - If `CurCh == NCH-1`: pulse `ScanDone`. If latched Continuous and no stop is pending, set `CurCh`=0 and go to SETTLE; otherwise go to IDLE.
    - If a stop is pending, go to IDLE without `ScanDone` unless this is the last channel.
- `Stop` sets a sticky stop-pending flag, consumed at STORE. `Stop` in IDLE is a no-op.
- `Start` and `Stop` high together in IDLE: `Start` wins, and the stop flag is not set.
- `Start` while `Busy`: ignored. Config changes during a scan take effect only at the next accepted `Start`.
- A rise in the last GATE cycle is counted. A rise in the STORE or SETTLE cycle is not.
- `Rst` mid-scan: state goes to IDLE, all results 0, `ValidMask` 0, stop flag cleared, synchronizers cleared. Nothing partial is stored.
- Reset values: `Busy`=0, `ScanDone`=0, `CurCh`=0, `RdData`=0, `ValidMask`=0.

## Timing
- Accepted `Start` at edge t: `Busy`=1 at t+1. SETTLE covers t+1..t+SETTLE. GATE covers the next G cycles, then STORE for 1 cycle.
- Per-channel period is `SETTLE`+G+1 cycles. A single scan takes NCH×(`SETTLE`+G+1) cycles. `Busy` falls the cycle after the final STORE, coincident with `ScanDone`.
- Pulse-to-detect latency is 3 cycles. Minimum countable pulse is 1 cycle high and 1 cycle low, so the maximum counted rate is `Clk`/2.
- `RdData` updates 1 cycle after `RdAddr` changes. A read of the channel being stored returns the new value in the cycle after STORE.

## Structure
- Shared package holds: state enum {IDLE, SETTLE, GATE, STORE}, `CNT_W`=32, `CH_W`=4, and the saturation constant.
- Sub-module `gated_edge_counter`: synchronized rise input, clear, enable, and a saturating 32-bit count. It is the reusable datapath.
- Synchronizers are instantiated per channel in the top level. The FSM and result bank (NCH×32 register file) also live in the top level.

## Test plan
- NCH=4, `SETTLE`=8, G=1000; ch i driven with period 10·(i+1) cycles (50 % duty); single scan → `Result` = {100, 50, 33/34, 25} ±1, `ScanDone` 1 pulse at cycle 4×1009+1, `ValidMask`=0xF.
- G=0, constant-high input on ch 0 then one pulse during the gate → G treated as 1; count is 0 or 1 as placed; a pulse placed in SETTLE or STORE gives 0.
- `Continuous`=1 for 3 scans, `Stop` asserted mid-GATE of ch 2 in scan 3 → ch 2 stored, `Busy` falls next cycle, no `ScanDone` for scan 3, ch 3 keeps its scan-2 value.
- Saturation with G=0xFFFFFFFF: force the counter to 0xFFFFFFFE, then 5 rises → stored 0xFFFFFFFF.
- `Rst` asserted during GATE of ch 1 → next cycle `Busy`=0, `ValidMask`=0, `RdData` of every address reads 0; a new `Start` then runs cleanly.
- `Start` while `Busy` with a new `GateCycles` → ignored; the period stays at the old G; `RdAddr`=NCH returns 0 after 1 cycle.
